// File: rtl/exp_pkg.sv
// Shared types, special values and the exp(x) piecewise-linear tables for exp_pipe.
// EXP_NEG_EN selects whether the negative-input table exists anywhere in the design.
package exp_pkg;

  typedef logic [15:0]        bf16_t;
  typedef logic signed [12:0] slope_t;

  localparam int EXP_E_LO = 123;
  localparam int EXP_E_HI = 131;
  localparam int TBL_N    = EXP_E_HI - EXP_E_LO + 1;

  localparam bf16_t BF16_ZERO = 16'h0000;
  localparam bf16_t BF16_ONE  = 16'h3F80;
  localparam bf16_t BF16_PINF = 16'h7F80;
  localparam bf16_t BF16_QNAN = 16'h7FC0;

  // Entry k covers exponent EXP_E_LO+k: base = exp(+2^(e-127)), slope to exp(+2^(e-126)).
  localparam bf16_t POS_BASE [0:TBL_N-1] = '{
    16'h3F88, 16'h3F91, 16'h3FA4, 16'h3FD3, 16'h402D,
    16'h40EC, 16'h425A, 16'h453A, 16'h4B07
  };
  localparam slope_t POS_SLOPE [0:TBL_N-1] = '{
    13'sd9, 13'sd19, 13'sd47, 13'sd90, 13'sd191,
    13'sd366, 13'sd736, 13'sd1485, 13'sd2952
  };

`ifdef EXP_NEG_EN
  localparam bf16_t NEG_BASE [0:TBL_N-1] = '{
    16'h3F70, 16'h3F61, 16'h3F47, 16'h3F1B, 16'h3EBC,
    16'h3E0A, 16'h3C96, 16'h39AF, 16'h33F1
  };
  localparam slope_t NEG_SLOPE [0:TBL_N-1] = '{
    -13'sd15, -13'sd26, -13'sd44, -13'sd95, -13'sd178,
    -13'sd372, -13'sd743, -13'sd1470, -13'sd2957
  };
`endif

endpackage

// File: rtl/exp_lane.sv
// One bf16 lane of exp_pipe: S1 classify/table read, S2 slope*mantissa, S3 add.
// Negative table path is present only when EXP_NEG_EN is defined; otherwise those inputs give 0x0000.
module exp_lane
  import exp_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_ld1,
  input  logic  i_ld2,
  input  logic  i_ld3,
  input  bf16_t i_x,
  output bf16_t o_y,
  output logic  o_ovf
);

  logic                w_s;
  logic [7:0]          w_e;
  logic [6:0]          w_m;
  logic [3:0]          w_idx;
  bf16_t               w_base;
  slope_t              w_slope;
  logic                w_ovf;
  logic signed [20:0]  w_prod;
  logic [16:0]         w_sum;

  bf16_t               r1_base;
  slope_t              r1_slope;
  logic [6:0]          r1_m;
  logic                r1_ovf;
  bf16_t               r2_base;
  logic signed [20:0]  r2_prod;
  logic                r2_ovf;
  bf16_t               r3_y;
  logic                r3_ovf;

  // Special results travel as a base with zero slope, so S2/S3 need no separate select.
  always_comb begin
    w_s     = i_x[15];
    w_e     = i_x[14:7];
    w_m     = i_x[6:0];
    w_idx   = w_e[3:0] - 4'(EXP_E_LO);
    w_base  = BF16_ZERO;
    w_slope = '0;
    w_ovf   = 1'b0;
    if (w_e == 8'hFF) begin
      if (w_m != 7'd0)
        w_base = BF16_QNAN;
      else if (!w_s)
        w_base = BF16_PINF;
    end else if (w_e < 8'(EXP_E_LO)) begin
      w_base = BF16_ONE;
    end else if (w_e > 8'(EXP_E_HI)) begin
      if (!w_s) begin
        w_base = BF16_PINF;
        w_ovf  = 1'b1;
      end
    end else if (!w_s) begin
      w_base  = POS_BASE[w_idx];
      w_slope = POS_SLOPE[w_idx];
    end else begin
`ifdef EXP_NEG_EN
      w_base  = NEG_BASE[w_idx];
      w_slope = NEG_SLOPE[w_idx];
`else
      w_base  = BF16_ZERO;
`endif
    end
  end

  assign w_prod = $signed({{8{r1_slope[12]}}, r1_slope}) * $signed({14'd0, r1_m});
  // Bits [20:7] of the product are the floor shift by 7; the add wraps to 16 bits.
  assign w_sum  = {1'b0, r2_base} + {{3{r2_prod[20]}}, r2_prod[20:7]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_base  <= '0;
      r1_slope <= '0;
      r1_m     <= '0;
      r1_ovf   <= 1'b0;
      r2_base  <= '0;
      r2_prod  <= '0;
      r2_ovf   <= 1'b0;
      r3_y     <= '0;
      r3_ovf   <= 1'b0;
    end else begin
      if (i_ld1) begin
        r1_base  <= w_base;
        r1_slope <= w_slope;
        r1_m     <= w_m;
        r1_ovf   <= w_ovf;
      end
      if (i_ld2) begin
        r2_base <= r1_base;
        r2_prod <= w_prod;
        r2_ovf  <= r1_ovf;
      end
      if (i_ld3) begin
        r3_y   <= w_sum[15:0];
        r3_ovf <= r2_ovf;
      end
    end
  end

  assign o_y   = r3_y;
  assign o_ovf = r3_ovf;

endmodule

// File: rtl/exp_pipe.sv
// Multi-lane bf16 e^x unit: 3-stage valid/ready pipeline around LANES exp_lane datapaths.
// Build option EXP_NEG_EN (see exp_pkg/exp_lane) enables the negative-input table.
module exp_pipe
  import exp_pkg::*;
#(
  parameter int LANES = 1,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*LANES-1:0]  in_data,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*LANES-1:0]  out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic [LANES-1:0]     out_ovf,
  output logic                 busy
);

  // Handshake: a beat moves on valid && ready at either port; each stage loads when
  // the stage after it is empty or advancing, and holds its contents otherwise.
  logic             r_v1, r_v2, r_v3;
  logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3;
  logic             w_en1, w_en2, w_en3;
  logic             w_ld1, w_ld2, w_ld3;

  assign w_en3 = !r_v3 || out_ready;
  assign w_en2 = !r_v2 || w_en3;
  assign w_en1 = !r_v1 || w_en2;

  assign w_ld1 = w_en1 && in_valid;
  assign w_ld2 = w_en2 && r_v1;
  assign w_ld3 = w_en3 && r_v2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_tag3 <= '0;
    end else begin
      if (w_en1) r_v1 <= in_valid;
      if (w_en2) r_v2 <= r_v1;
      if (w_en3) r_v3 <= r_v2;
      if (w_ld1) r_tag1 <= in_tag;
      if (w_ld2) r_tag2 <= r_tag1;
      if (w_ld3) r_tag3 <= r_tag2;
    end
  end

  assign in_ready  = w_en1;
  assign out_valid = r_v3;
  assign out_tag   = r_tag3;
  assign busy      = r_v1 || r_v2 || r_v3;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    bf16_t w_y;
    exp_lane u_lane (
      .clk   (clk),
      .rst   (rst),
      .i_ld1 (w_ld1),
      .i_ld2 (w_ld2),
      .i_ld3 (w_ld3),
      .i_x   (in_data[16*g +: 16]),
      .o_y   (w_y),
      .o_ovf (out_ovf[g])
    );
    assign out_data[16*g +: 16] = w_y;
  end

endmodule

// File: tb/tb_exp_pipe.sv
// Directed bench for exp_pipe (LANES=1): special values, table path, latency,
// backpressure ordering/stability and mid-stream reset. Honors EXP_NEG_EN for expectations.
module tb_exp_pipe;

  localparam int LANES = 1;
  localparam int TAG_W = 4;
  localparam int NV    = 17;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       in_data = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [15:0]       out_data;
  logic [TAG_W-1:0]  out_tag;
  logic [LANES-1:0]  out_ovf;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [20:0] exp_q[$];   // {ovf, tag, data}

  logic [15:0] vx [NV];
  logic [15:0] vy [NV];
  logic        vo [NV];

  exp_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic run_single(input logic [15:0] x, input logic [3:0] tag,
                            input logic [15:0] y, input logic ovf);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = x;
    in_tag   = tag;
    @(negedge clk);
    check("single_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 3);
    check("data", out_data, y);
    check("tag", out_tag, tag);
    check("ovf", out_ovf, ovf);
    @(posedge clk); #1;
  endtask

  task automatic load_vectors();
    vx[0]  = 16'h3F80; vy[0]  = 16'h402D; vo[0]  = 1'b0;  // 1.0
    vx[1]  = 16'h3FC0; vy[1]  = 16'h408C; vo[1]  = 1'b0;  // 1.5
    vx[2]  = 16'h0000; vy[2]  = 16'h3F80; vo[2]  = 1'b0;
    vx[3]  = 16'h3C00; vy[3]  = 16'h3F80; vo[3]  = 1'b0;  // e=120
    vx[4]  = 16'h4300; vy[4]  = 16'h7F80; vo[4]  = 1'b1;  // e=134
    vx[5]  = 16'hC300; vy[5]  = 16'h0000; vo[5]  = 1'b0;
    vx[6]  = 16'h7FC1; vy[6]  = 16'h7FC0; vo[6]  = 1'b0;  // NaN
    vx[7]  = 16'hFF80; vy[7]  = 16'h0000; vo[7]  = 1'b0;  // -inf
    vx[8]  = 16'h7F80; vy[8]  = 16'h7F80; vo[8]  = 1'b0;  // +inf, not an overflow
    vx[9]  = 16'h3D00; vy[9]  = 16'h3F80; vo[9]  = 1'b0;  // e=122 edge
    vx[10] = 16'h3D80; vy[10] = 16'h3F88; vo[10] = 1'b0;  // e=123 edge
    vx[11] = 16'h3DFF; vy[11] = 16'h3F90; vo[11] = 1'b0;  // 0x3F88 + floor(9*127/128)
    vx[12] = 16'h4180; vy[12] = 16'h4B07; vo[12] = 1'b0;  // e=131 edge
    vx[13] = 16'h4200; vy[13] = 16'h7F80; vo[13] = 1'b1;  // e=132 edge
    vx[14] = 16'h8000; vy[14] = 16'h3F80; vo[14] = 1'b0;  // -0
`ifdef EXP_NEG_EN
    vx[15] = 16'hBF80; vy[15] = 16'h3EBC; vo[15] = 1'b0;
    vx[16] = 16'hBFC0; vy[16] = 16'h3E63; vo[16] = 1'b0;  // 0x3EBC + floor(-178*64/128)
`else
    vx[15] = 16'hBF80; vy[15] = 16'h0000; vo[15] = 1'b0;
    vx[16] = 16'hBFC0; vy[16] = 16'h0000; vo[16] = 1'b0;
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] bx [4];
    logic [15:0] by [4];
    logic        bo [4];
    logic [20:0] e;
    int k;
    int n;
    int guard;

    load_vectors();
    bx[0] = 16'h3F80; by[0] = 16'h402D; bo[0] = 1'b0;
    bx[1] = 16'h3FC0; by[1] = 16'h408C; bo[1] = 1'b0;
    bx[2] = 16'h4300; by[2] = 16'h7F80; bo[2] = 1'b1;
    bx[3] = 16'h0000; by[3] = 16'h3F80; bo[3] = 1'b0;

    // reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);

    // directed single beats
    for (int i = 0; i < NV; i++)
      run_single(vx[i], 4'(i), vy[i], vo[i]);

    // backpressure: 5 stalled cycles offering tags 1..4
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (k < 4) begin
        in_valid = 1'b1;
        in_data  = bx[k];
        in_tag   = 4'(k + 1);
      end
      @(negedge clk);
      if (c >= 3) begin
        check("stall_data", out_data, by[0]);
        check("stall_tag", out_tag, 1);
        check("stall_valid", out_valid, 1);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({bo[k], 4'(k + 1), by[k]});
        k++;
      end
    end
    check("bp_accepted", k, 3);
    check("bp_in_ready", in_ready, 0);
    check("bp_busy", busy, 1);

    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0;
    guard = 0;
    while (n < 4 && guard < 30) begin
      @(negedge clk);
      guard++;
      if (in_valid && in_ready) begin
        exp_q.push_back({bo[k], 4'(k + 1), by[k]});
        k++;
      end
      if (out_valid) begin
        check("bp_queue_nonempty", exp_q.size() > 0, 1);
        e = exp_q.pop_front();
        check("bp_data", out_data, e[15:0]);
        check("bp_tag", out_tag, e[19:16]);
        check("bp_ovf", out_ovf, e[20]);
        n++;
      end
      @(posedge clk); #1;
      if (k == 4) in_valid = 1'b0;
    end
    check("bp_drained", n, 4);
    in_valid = 1'b0;

    // mid-stream reset with two beats in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h3F80;
    in_tag    = 4'd5;
    @(posedge clk); #1;
    in_data   = 16'h0000;
    in_tag    = 4'd6;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    check("mid_rst_out_valid2", out_valid, 0);
    out_ready = 1'b1;
    exp_q.delete();
    run_single(16'h3FC0, 4'd7, 16'h408C, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/exp_pipe.md
# exp_pipe

Pipelined, multi-lane bfloat16 exponential unit: computes an approximation of e^x per lane using a per-exponent piecewise-linear table applied to the raw bf16 bit pattern. It sits in the activation/softmax datapath behind a valid/ready stream. It extends the single-lane, positive-only, unhandshaked exp approximation to:
- parametrised lane count and sideband tag;
- negative-input support;
- IEEE special-value handling;
- a 3-stage backpressured pipeline.

## Interface
- LANES, 1: number of independent bf16 lanes per beat.
- TAG_W, 4: width of the user tag carried alongside each beat.

- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- in_data  input  16*LANES  bf16 operands; lane i occupies bits [16i+15:16i].
- in_tag  input  TAG_W  opaque tag; returned unchanged with the result.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  16*LANES  bf16 results, same lane packing as the input.
- out_tag  output  TAG_W  tag of the result beat.
- out_ovf  output  LANES  per-lane flag: a finite input saturated to +inf.
- busy  output  1  any pipeline stage holds a valid beat.

## Operation
Per lane, split the input into s = x[15], e = x[14:7] (8 bits), m = x[6:0].

Classification, first match wins:
- e == 255, m != 0: result 0x7FC0 (canonical NaN).
- e == 255, m == 0, s = 0: result 0x7F80.
- e == 255, m == 0, s = 1: result 0x0000.
- e <= 122, including zeros and denormals: result 0x3F80 (1.0).
- e >= 132, s = 0: result 0x7F80, out_ovf = 1.
- e >= 132, s = 1: result 0x0000.
- 123 <= e <= 131: table path.

Table path:
- Read base[s][e-123] (16-bit) and slope[s][e-123] (signed 13-bit).
- result = base + ((slope * m) >>> 7); arithmetic shift, floor.
- All arithmetic is done in 17-bit signed; only the low 16 bits are kept.

Table contents:
- base = bf16 bit pattern, truncated toward zero, of exp(±2^(e-127)).
- slope = truncated bits of exp(±2^(e-126)) minus base.
- Positive entries, e = 123..131, base: 0x3F88, 0x3F91, 0x3FA4, 0x3FD3, 0x402D, 0x40EC, 0x425A, 0x453A, 0x4B07.
- Positive entries, e = 123..131, slope: 9, 19, 47, 90, 191, 366, 736, 1485, 2952.
- Negative entries are generated by the same rule; for example, e = 127 gives base 0x3EBC, slope −178.

Pipeline (all lanes move in lockstep):
- S1: classify and read the table.
- S2: multiply slope × m.
- S3: add and select; this stage drives the out_* ports.
- Each stage register loads when its downstream stage is empty or advancing (bubble-collapsing).
- in_ready = !S1.valid || S1 advancing. A combinational path out_ready → in_ready is permitted.
- A beat transfers on valid && ready at either port.
- out_data, out_tag and out_ovf are held stable while out_valid && !out_ready.
- Beats are never dropped, duplicated or reordered.

## Timing
- Latency: a beat accepted at cycle t appears with out_valid = 1 at cycle t+3 when out_ready stays high.
- Throughput: one beat per cycle.
- Capacity: 3 beats in flight. With out_ready low, exactly 3 beats are accepted, after which in_ready = 0.
- Reset values: out_valid = 0, out_data = 0, out_tag = 0, out_ovf = 0, busy = 0, all stage valids = 0. in_ready = 1 in the first cycle after rst deasserts.
- rst asserted mid-stream: all in-flight beats are discarded, and out_valid is 0 from the cycle after rst is sampled high.
- Simultaneous accept and emit with the pipeline full is legal; occupancy stays 3.

## Configuration
- EXP_NEG_EN defined: negative table is compiled in, and negative finite inputs with 123 <= e <= 131 use it.
- EXP_NEG_EN undefined: no negative table is instantiated, and those inputs produce 0x0000. All other classification rows are unchanged.

## Structure
- Package exp_pkg holds:
  - the bf16 typedef;
  - constants EXP_E_LO = 123 and EXP_E_HI = 131;
  - special values BF16_ONE = 0x3F80, BF16_PINF = 0x7F80, BF16_QNAN = 0x7FC0;
  - the positive and negative base/slope constant arrays.
- Sub-module exp_lane: per-lane S1–S3 datapath and data registers, instantiated LANES times.
- exp_pipe top owns the shared valid/ready control, the tag pipeline and busy.

## Test plan
- 0x3F80 (1.0), out_ready = 1 → 0x402D at t+3, out_ovf = 0, tag echoed.
- 0x3FC0 (1.5) → 0x402D + (191*64 >> 7) = 0x408C. 0x0000 → 0x3F80. 0x3C00 (e = 120) → 0x3F80.
- 0x4300 (e = 134) → 0x7F80 with out_ovf = 1. 0xC300 → 0x0000. 0x7FC1 → 0x7FC0. 0xFF80 → 0x0000.
- With EXP_NEG_EN: 0xBF80 (−1.0) → 0x3EBC and 0xBFC0 → 0x3E63. Without the macro: both → 0x0000.
- out_ready low for 5 cycles while offering 4 beats with tags 1..4 → tags 1–3 accepted, then in_ready = 0. On release, outputs appear in order 1, 2, 3, 4 with data stable during the stall.
- rst pulsed with 2 beats in flight → out_valid = 0 the next cycle and busy = 0. A fresh beat afterwards emerges after exactly 3 cycles.
